// File: rtl/pkt_tx_arbiter.sv
// Round-robin owner selection for a shared packet transmit path; sequences
// start, payload bytes and EOF by counting serializer done pulses.
module pkt_tx_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int LEN_W   = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] pkt_len,
  input  logic [NUM_REQ*8-1:0]     byte_data,
  input  logic                     done,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       byte_ack,
  output logic [NUM_REQ-1:0]       pkt_done,
  output logic                     start,
  output logic                     end_packet,
  output logic [7:0]               data_dyn,
  output logic                     busy
);

  typedef enum logic [2:0] {
    A_IDLE      = 3'd0,
    A_START     = 3'd1,
    A_WAIT_SOF  = 3'd2,
    A_WAIT_DATA = 3'd3,
    A_WAIT_EOF  = 3'd4
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   byte_cnt_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               start_r;

  logic [LEN_W-1:0]   len_arr_s  [NUM_REQ];
  logic [7:0]         byte_arr_s [NUM_REQ];
  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   idx_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic               last_s;
  int                 sum_s;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign len_arr_s[i]  = pkt_len[i*LEN_W +: LEN_W];
    assign byte_arr_s[i] = byte_data[i*8 +: 8];
  end

  // Pick the first active request at or after the round-robin pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    sum_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = int'(rr_ptr_r) + k;
      if (sum_s >= NUM_REQ) begin
        sum_s = sum_s - NUM_REQ;
      end else begin
        sum_s = sum_s;
      end
      idx_s = IDX_W'(sum_s);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Priority rotates to the requester after the one just served.
  always_comb begin
    if (owner_r == IDX_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + IDX_W'(1);
    end
  end

  // Done-qualified pulses and payload steering toward the framing FSM.
  always_comb begin
    last_s   = (state_r == A_WAIT_DATA) && (byte_cnt_r == (len_r - LEN_W'(1)));
    byte_ack = '0;
    pkt_done = '0;
    if (done && state_r == A_WAIT_DATA) begin
      byte_ack = grant_r;
    end else if (done && state_r == A_WAIT_EOF) begin
      pkt_done = grant_r;
    end else begin
      byte_ack = '0;
    end
    if (grant_r != '0) begin
      data_dyn = byte_arr_s[owner_r];
    end else begin
      data_dyn = 8'h00;
    end
  end

  assign end_packet = last_s;
  assign grant      = grant_r;
  assign start      = start_r;
  assign busy       = (state_r != A_IDLE);

  // Arbitration and packet sequencing state machine.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= A_IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      len_r      <= '0;
      byte_cnt_r <= '0;
      grant_r    <= '0;
      start_r    <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        A_IDLE: begin
          if (found_s) begin
            owner_r <= pick_s;
            // A zero length still sends one payload byte.
            len_r   <= (len_arr_s[pick_s] == '0) ? LEN_W'(1) : len_arr_s[pick_s];
            grant_r <= NUM_REQ'(1) << pick_s;
            start_r <= 1'b1;
            state_r <= A_START;
          end
        end
        A_START: state_r <= A_WAIT_SOF;
        A_WAIT_SOF: begin
          if (done) begin
            byte_cnt_r <= '0;
            state_r    <= A_WAIT_DATA;
          end
        end
        A_WAIT_DATA: begin
          if (done) begin
            byte_cnt_r <= byte_cnt_r + LEN_W'(1);
            if (last_s) begin
              state_r <= A_WAIT_EOF;
            end
          end
        end
        A_WAIT_EOF: begin
          if (done) begin
            grant_r  <= '0;
            rr_ptr_r <= next_ptr_s;
            state_r  <= A_IDLE;
          end
        end
        default: begin
          grant_r <= '0;
          state_r <= A_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Directed bench for pkt_tx_arbiter: single packet, round-robin order,
// length edges, spurious done, dropped request and reset mid-packet.
module tb_pkt_tx_arbiter;

  logic        clk;
  logic        n_rst;
  logic [3:0]  req;
  logic [31:0] pkt_len;
  logic [31:0] byte_data;
  logic        done;
  logic [3:0]  grant;
  logic [3:0]  byte_ack;
  logic [3:0]  pkt_done;
  logic        start;
  logic        end_packet;
  logic [7:0]  data_dyn;
  logic        busy;

  int passed = 0;
  int total  = 0;

  pkt_tx_arbiter #(.NUM_REQ(4), .LEN_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .pkt_len(pkt_len),
    .byte_data(byte_data), .done(done), .grant(grant), .byte_ack(byte_ack),
    .pkt_done(pkt_done), .start(start), .end_packet(end_packet),
    .data_dyn(data_dyn), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // One done pulse; outputs sampled mid-cycle while done is high.
  task automatic pulse(input string tag, input logic [3:0] ack_e,
                       input logic [3:0] pd_e, input logic ep_e);
    done = 1'b1;
    #1;
    check({tag, "_ack"}, 32'(byte_ack), 32'(ack_e));
    check({tag, "_pd"},  32'(pkt_done), 32'(pd_e));
    check({tag, "_ep"},  32'(end_packet), 32'(ep_e));
    tick();
    done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_data"},  32'(data_dyn), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_g;
    n_rst     = 1'b0;
    req       = 4'b0000;
    done      = 1'b0;
    pkt_len   = {8'd1, 8'd1, 8'd3, 8'd1};
    byte_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    gap(2);
    check_idle("reset");
    check("reset_ep", 32'(end_packet), 32'd0);
    n_rst = 1'b1;
    tick();

    // Single packet from requester 1, three payload bytes.
    req = 4'b0010;
    tick();
    check("sp_grant", 32'(grant), 32'h2);
    check("sp_start", 32'(start), 32'd1);
    check("sp_busy",  32'(busy), 32'd1);
    check("sp_data0", 32'(data_dyn), 32'hB1);
    req = 4'b0000;
    tick();
    check("sp_start_off", 32'(start), 32'd0);
    gap(3);
    pulse("sp_sof", 4'b0000, 4'b0000, 1'b0);
    gap(3);
    pulse("sp_b0", 4'b0010, 4'b0000, 1'b0);
    byte_data[15:8] = 8'hB2;
    #1;
    check("sp_data1", 32'(data_dyn), 32'hB2);
    gap(3);
    pulse("sp_b1", 4'b0010, 4'b0000, 1'b0);
    gap(3);
    pulse("sp_b2", 4'b0010, 4'b0000, 1'b1);
    check("sp_eof_ep", 32'(end_packet), 32'd0);
    gap(3);
    pulse("sp_eof", 4'b0000, 4'b0010, 1'b0);
    check_idle("sp_end");

    // Round-robin with all requesters held and single-byte packets.
    n_rst = 1'b0;
    tick();
    n_rst   = 1'b1;
    pkt_len = {8'd1, 8'd1, 8'd1, 8'd1};
    tick();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_start", 32'(start), 32'd1);
      check("rr_data",  32'(data_dyn), 32'(byte_data[(i % 4)*8 +: 8]));
      tick();
      pulse("rr_sof",  4'b0000, 4'b0000, 1'b0);
      pulse("rr_byte", exp_g,   4'b0000, 1'b1);
      pulse("rr_eof",  4'b0000, exp_g,   1'b0);
    end
    req = 4'b0000;
    tick();
    check_idle("rr_end");

    // Zero length behaves as one byte.
    pkt_len = {8'd255, 8'd0, 8'd1, 8'd4};
    req = 4'b0100;
    tick();
    check("z_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    tick();
    pulse("z_sof", 4'b0000, 4'b0000, 1'b0);
    check("z_ep_pre", 32'(end_packet), 32'd1);
    pulse("z_byte", 4'b0100, 4'b0000, 1'b1);
    pulse("z_eof",  4'b0000, 4'b0100, 1'b0);

    // Maximum length: end_packet only on the 255th byte.
    req = 4'b1000;
    tick();
    check("m_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    tick();
    pulse("m_sof", 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 255; k++) begin
      pulse("m_byte", 4'b1000, 4'b0000, (k == 254) ? 1'b1 : 1'b0);
    end
    pulse("m_eof", 4'b0000, 4'b1000, 1'b0);

    // Spurious done while idle.
    done = 1'b1;
    gap(3);
    check_idle("sp_done");
    check("sp_done_ack", 32'(byte_ack), 32'd0);
    check("sp_done_pd",  32'(pkt_done), 32'd0);
    done = 1'b0;
    tick();

    // Request dropped after first byte; done during start ignored.
    req = 4'b0001;
    tick();
    check("d_grant", 32'(grant), 32'h1);
    pulse("d_start_done", 4'b0000, 4'b0000, 1'b0);
    pulse("d_sof", 4'b0000, 4'b0000, 1'b0);
    pulse("d_b0", 4'b0001, 4'b0000, 1'b0);
    req = 4'b0000;
    pkt_len[7:0] = 8'd1;
    pulse("d_b1", 4'b0001, 4'b0000, 1'b0);
    pulse("d_b2", 4'b0001, 4'b0000, 1'b0);
    pulse("d_b3", 4'b0001, 4'b0000, 1'b1);
    pulse("d_eof", 4'b0000, 4'b0001, 1'b0);

    // Reset in the middle of a packet from requester 2.
    pkt_len[23:16] = 8'd5;
    req = 4'b0100;
    tick();
    check("r_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    tick();
    pulse("r_sof", 4'b0000, 4'b0000, 1'b0);
    pulse("r_b0", 4'b0100, 4'b0000, 1'b0);
    pulse("r_b1", 4'b0100, 4'b0000, 1'b0);
    n_rst = 1'b0;
    #1;
    check_idle("r_async");
    tick();
    n_rst = 1'b1;
    req = 4'b1001;
    tick();
    check("r_regrant", 32'(grant), 32'h1);
    check("r_start",   32'(start), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
